rr_sel_arbiter16: RTL and testbench
===================================

Name: rr_sel_arbiter16

Overview:
- Round-robin arbiter/scheduler that shares the 16:1 bit multiplexer (s16bitmux) among 16 requesters.
- Grants one requester at a time and drives the mux's 4-bit `sel` from registered state.
- Handshakes each transferred beat with the downstream consumer using valid/ready.
- Supports a bounded "lock" so one requester can hold the mux for a burst without starving the others.

Parameters:
- MAX_BEATS, default 4: maximum consecutive handshaked beats one requester may take under lock before a forced release; legal range 1..15.
- CNT_W, default 4: width of the beat counter; must hold MAX_BEATS.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  16  request vector; bit i = requester i wants the mux.
- lock  input  1  sampled at a handshake; high = the current owner wants to keep the grant for another beat.
- ready  input  1  downstream accepts the current mux output this cycle.
- gnt  output  16  one-hot grant, registered; all zero when idle.
- sel  output  4  registered binary index of the granted requester; drives the s16bitmux select.
- valid  output  1  registered; high while a grant is active, meaning the mux output is presented.
- beat_cnt  output  CNT_W  registered count of beats taken by the current owner in its current tenure.

Behaviour:
- Reset, synchronous, when rst=1 at an edge:
  - State becomes IDLE.
  - ptr=0, gnt=0, sel=0, valid=0, beat_cnt=0.
  - rst overrides all other inputs, including mid-grant; no handshake completes on that edge.
- Internal priority pointer ptr[3:0]. Search order is ptr, ptr+1, ..., ptr+15, mod 16; the first set req bit wins.
- State IDLE (valid=0, gnt=0, sel holds its last value):
  - If req is nonzero at edge k, the winner w is registered at edge k: gnt=1<<w, sel=w, valid=1, beat_cnt=0, state becomes GRANT.
  - Latency: one cycle from req to valid.
- State GRANT (valid=1; gnt and sel stable):
  - A handshake is valid&&ready at an edge.
  - Handshake, keep grant: lock=1 AND req[sel]=1 AND beat_cnt+1 < MAX_BEATS. Stay in GRANT and increment beat_cnt; ptr is unchanged.
  - Handshake, release: any other handshake. ptr becomes sel+1, wrapping 15 to 0.
  - Withdrawal: no handshake and req[sel]=0. Release without a beat; ptr becomes sel+1.
  - No handshake and req[sel]=1: hold everything. ready may stall indefinitely.
- Release (same edge as the handshake or withdrawal):
  - Re-arbitrate immediately using the updated pointer (sel+1) and the current req vector.
  - If a winner exists, it takes over with no idle cycle: gnt and sel change, valid stays 1, beat_cnt=0.
  - The releasing requester, if still requesting, has lowest priority.
  - If no request remains, go to IDLE: valid=0, gnt=0, beat_cnt=0.
- Invariants:
  - gnt is always zero or one-hot, and gnt[sel]=valid.
  - sel never changes while valid=1 without a handshake or withdrawal.
  - No requester waits more than 15 tenures, each at most MAX_BEATS beats.
- Simultaneous events:
  - req rising for another requester during GRANT has no effect until the next release.
  - lock is ignored outside a handshake.
- Top-level wiring: mux out = in[sel]. Data beat j of owner i is in[i] on a handshake edge.

Test Plan:
- Reset, then req=16'h0000 for 5 cycles -> valid=0, gnt=0, sel=0, beat_cnt=0 throughout; asserting rst while in GRANT returns the same values on the next edge.
- Single requester: req=16'h0020, ready=1, lock=0 -> one cycle later valid=1, sel=5, gnt=16'h0020. The grant re-issues each cycle with sel=5; ptr becomes 6 on each release.
- Rotation: req=16'h8101, ready=1, lock=0 from reset -> sel sequence 0, 8, 15, 0, 8, ... with valid held at 1 and no idle cycles.
- Lock with burst limit: MAX_BEATS=4, req=16'h0006, lock=1, ready=1 -> sel=1 for exactly 4 handshakes, beat_cnt counting 0..3, then sel=2 for 4 beats, then back to sel=1.
- Backpressure and withdrawal: granted sel=3 with ready=0 for 10 cycles -> gnt/sel/valid stay stable. Then req[3] drops with req=16'h1000 -> next edge sel=12, and no beat is counted for requester 3.
- Wrap-around: grant at sel=15 released with req=16'h8001 -> next owner is sel=0 (ptr wrapped to 0), not 15.

Source files
------------

// File: rtl/rr_sel_arbiter16_if.sv
// Request/grant bundle between the requesters, the downstream consumer and the
// round-robin arbiter that owns the s16bitmux select.
interface rr_sel_arbiter16_if #(
  parameter int CNT_W = 4
);
  logic [15:0]      req;
  logic             lock;
  logic             ready;
  logic [15:0]      gnt;
  logic [3:0]       sel;
  logic             valid;
  logic [CNT_W-1:0] beat_cnt;

  // Requester/consumer side
  modport master (
    output req, lock, ready,
    input  gnt, sel, valid, beat_cnt
  );

  // Arbiter side
  modport slave (
    input  req, lock, ready,
    output gnt, sel, valid, beat_cnt
  );
endinterface

// File: rtl/rr_sel_arbiter16.sv
// Round-robin arbiter sharing a 16:1 bit mux among 16 requesters; registered
// one-hot grant and binary select, valid/ready beat handshake, bounded lock.
module rr_sel_arbiter16 #(
  parameter int MAX_BEATS = 4,
  parameter int CNT_W     = 4
) (
  input logic               clk,
  input logic               rst,
  rr_sel_arbiter16_if.slave bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [CNT_W:0] BEAT_LIM = MAX_BEATS[CNT_W:0];

  state_t           state_p1, state_nxt;
  logic [3:0]       ptr_p1, ptr_nxt;
  logic [15:0]      gnt_p1, gnt_nxt;
  logic [3:0]       sel_p1, sel_nxt;
  logic             vld_p1, vld_nxt;
  logic [CNT_W-1:0] cnt_p1, cnt_nxt;

  logic             hs;
  logic             keep;
  logic             rel;
  logic [3:0]       base;
  logic [4:0]       pick;

  // {found, index} of the first set request at or after base, modulo 16.
  function automatic logic [4:0] rr_pick(input logic [15:0] r, input logic [3:0] b);
    logic [4:0] res;
    logic [3:0] idx;
    res = '0;
    for (int i = 15; i >= 0; i--) begin
      idx = b + 4'(i);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  function automatic logic [15:0] onehot16(input logic [3:0] i);
    return 16'd1 << i;
  endfunction

  // True when the beat now completing would exhaust the owner's tenure.
  function automatic logic last_beat(input logic [CNT_W-1:0] c);
    return ({1'b0, c} + {{CNT_W{1'b0}}, 1'b1}) >= BEAT_LIM;
  endfunction

  // Stage p0: handshake decode and re-arbitration from the current inputs
  always_comb begin
    state_nxt = state_p1;
    ptr_nxt   = ptr_p1;
    gnt_nxt   = gnt_p1;
    sel_nxt   = sel_p1;
    vld_nxt   = vld_p1;
    cnt_nxt   = cnt_p1;

    hs   = vld_p1 & bus.ready;
    keep = hs & bus.lock & bus.req[sel_p1] & ~last_beat(cnt_p1);
    rel  = (state_p1 == GRANT) & ((hs & ~keep) | (~hs & ~bus.req[sel_p1]));
    // On release the search starts just past the outgoing owner, so it ranks last.
    base = (state_p1 == GRANT) ? sel_p1 + 4'd1 : ptr_p1;
    pick = rr_pick(bus.req, base);

    case (state_p1)
      IDLE: begin
        if (pick[4]) begin
          state_nxt = GRANT;
          gnt_nxt   = onehot16(pick[3:0]);
          sel_nxt   = pick[3:0];
          vld_nxt   = 1'b1;
          cnt_nxt   = '0;
        end
      end
      GRANT: begin
        if (keep) begin
          cnt_nxt = cnt_p1 + {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (rel) begin
          ptr_nxt = base;
          cnt_nxt = '0;
          if (pick[4]) begin
            gnt_nxt = onehot16(pick[3:0]);
            sel_nxt = pick[3:0];
            vld_nxt = 1'b1;
          end else begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
            vld_nxt   = 1'b0;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
        vld_nxt   = 1'b0;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Stage p1: registered grant state driving the mux select
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p1 <= IDLE;
      ptr_p1   <= '0;
      gnt_p1   <= '0;
      sel_p1   <= '0;
      vld_p1   <= 1'b0;
      cnt_p1   <= '0;
    end else begin
      state_p1 <= state_nxt;
      ptr_p1   <= ptr_nxt;
      gnt_p1   <= gnt_nxt;
      sel_p1   <= sel_nxt;
      vld_p1   <= vld_nxt;
      cnt_p1   <= cnt_nxt;
    end
  end

  assign bus.gnt      = gnt_p1;
  assign bus.sel      = sel_p1;
  assign bus.valid    = vld_p1;
  assign bus.beat_cnt = cnt_p1;

  a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_p1));
  a_gnt_sel:     assert property (@(posedge clk) disable iff (rst) gnt_p1[sel_p1] == vld_p1);
  a_stall_hold:  assert property (@(posedge clk) disable iff (rst)
                   (vld_p1 && !bus.ready && bus.req[sel_p1]) |=> ($stable(sel_p1) && $stable(gnt_p1)));

endmodule

// File: tb/tb_rr_sel_arbiter16.sv
// Directed bench for rr_sel_arbiter16: a per-cycle vector table plus hand-written
// backpressure, withdrawal, wrap-around and mid-grant reset sequences.
module tb_rr_sel_arbiter16;

  localparam int MAXB = 4;
  localparam int CW   = 4;

  typedef struct {
    logic        rst;
    logic [15:0] req;
    logic        lock;
    logic        ready;
    logic [15:0] e_gnt;
    logic [3:0]  e_sel;
    logic        e_vld;
    logic [3:0]  e_cnt;
  } vec_t;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;
  vec_t vecs[$];

  rr_sel_arbiter16_if #(.CNT_W(CW)) bus ();

  rr_sel_arbiter16 #(.MAX_BEATS(MAXB), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [15:0] rq, input logic lk, input logic rd,
                     input logic [15:0] eg, input logic [3:0] es, input logic ev, input logic [3:0] ec);
    vecs.push_back('{r, rq, lk, rd, eg, es, ev, ec});
  endtask

  task automatic step(input logic r, input logic [15:0] rq, input logic lk, input logic rd,
                      input logic [15:0] eg, input logic [3:0] es, input logic ev, input logic [3:0] ec,
                      input string tag);
    rst       = r;
    bus.req   = rq;
    bus.lock  = lk;
    bus.ready = rd;
    @(posedge clk);
    #1;
    chk({tag, ".gnt"},      32'(bus.gnt),      32'(eg));
    chk({tag, ".sel"},      32'(bus.sel),      32'(es));
    chk({tag, ".valid"},    32'(bus.valid),    32'(ev));
    chk({tag, ".beat_cnt"}, 32'(bus.beat_cnt), 32'(ec));
    chk({tag, ".onehot0"},  32'($onehot0(bus.gnt)), 32'd1);
  endtask

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    rst       = 1'b1;
    bus.req   = '0;
    bus.lock  = 1'b0;
    bus.ready = 1'b0;

    // Reset, then idle
    add(1, 16'h0000, 0, 0, 16'h0000, 4'd0, 0, 4'd0);
    for (int i = 0; i < 5; i++) add(0, 16'h0000, 0, 0, 16'h0000, 4'd0, 0, 4'd0);
    // Single requester 5 re-granted every cycle, then drop to idle with sel held
    add(0, 16'h0020, 0, 1, 16'h0020, 4'd5, 1, 4'd0);
    add(0, 16'h0020, 0, 1, 16'h0020, 4'd5, 1, 4'd0);
    add(0, 16'h0020, 0, 1, 16'h0020, 4'd5, 1, 4'd0);
    add(0, 16'h0000, 0, 1, 16'h0000, 4'd5, 0, 4'd0);
    add(0, 16'h0000, 0, 1, 16'h0000, 4'd5, 0, 4'd0);
    // Rotation 0 -> 8 -> 15 -> 0 -> 8 from reset
    add(1, 16'h8101, 0, 1, 16'h0000, 4'd0, 0, 4'd0);
    add(0, 16'h8101, 0, 1, 16'h0001, 4'd0, 1, 4'd0);
    add(0, 16'h8101, 0, 1, 16'h0100, 4'd8, 1, 4'd0);
    add(0, 16'h8101, 0, 1, 16'h8000, 4'd15, 1, 4'd0);
    add(0, 16'h8101, 0, 1, 16'h0001, 4'd0, 1, 4'd0);
    add(0, 16'h8101, 0, 1, 16'h0100, 4'd8, 1, 4'd0);
    // Lock burst: owner 8 not requesting -> release to 1; 4 beats each for 1 and 2
    add(0, 16'h0006, 1, 1, 16'h0002, 4'd1, 1, 4'd0);
    add(0, 16'h0006, 1, 1, 16'h0002, 4'd1, 1, 4'd1);
    add(0, 16'h0006, 1, 1, 16'h0002, 4'd1, 1, 4'd2);
    add(0, 16'h0006, 1, 1, 16'h0002, 4'd1, 1, 4'd3);
    add(0, 16'h0006, 1, 1, 16'h0004, 4'd2, 1, 4'd0);
    add(0, 16'h0006, 1, 1, 16'h0004, 4'd2, 1, 4'd1);
    add(0, 16'h0006, 1, 1, 16'h0004, 4'd2, 1, 4'd2);
    add(0, 16'h0006, 1, 1, 16'h0004, 4'd2, 1, 4'd3);
    add(0, 16'h0006, 1, 1, 16'h0002, 4'd1, 1, 4'd0);
    // lock without handshake is ignored; then one locked beat; reset mid-tenure
    add(0, 16'h0006, 1, 0, 16'h0002, 4'd1, 1, 4'd0);
    add(0, 16'h0006, 1, 1, 16'h0002, 4'd1, 1, 4'd1);
    add(1, 16'h0006, 1, 1, 16'h0000, 4'd0, 0, 4'd0);
    add(0, 16'h0000, 0, 1, 16'h0000, 4'd0, 0, 4'd0);

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i].rst, vecs[i].req, vecs[i].lock, vecs[i].ready,
           vecs[i].e_gnt, vecs[i].e_sel, vecs[i].e_vld, vecs[i].e_cnt, $sformatf("v%0d", i));

    // Backpressure on owner 3 with other requests arriving, then withdrawal to 12
    step(1, 16'h0000, 0, 0, 16'h0000, 4'd0, 0, 4'd0, "bp_rst");
    step(0, 16'h0008, 0, 0, 16'h0008, 4'd3, 1, 4'd0, "bp_grant");
    for (int i = 0; i < 10; i++)
      step(0, 16'($urandom) | 16'h0008, 1'($urandom), 0, 16'h0008, 4'd3, 1, 4'd0, $sformatf("bp_hold%0d", i));
    step(0, 16'h1000, 0, 0, 16'h1000, 4'd12, 1, 4'd0, "bp_withdraw");
    step(0, 16'h1000, 0, 1, 16'h1000, 4'd12, 1, 4'd0, "bp_regrant");

    // Wrap-around: release from 15 goes to 0, not back to 15
    step(1, 16'h0000, 0, 0, 16'h0000, 4'd0, 0, 4'd0, "wr_rst");
    step(0, 16'h8000, 0, 0, 16'h8000, 4'd15, 1, 4'd0, "wr_grant15");
    step(0, 16'h8001, 0, 1, 16'h0001, 4'd0, 1, 4'd0, "wr_to0");
    step(0, 16'h8001, 0, 1, 16'h8000, 4'd15, 1, 4'd0, "wr_to15");

    // Reset while granted with handshake pending: no beat, all cleared
    step(1, 16'h8001, 1, 1, 16'h0000, 4'd0, 0, 4'd0, "mid_rst");
    step(0, 16'h0000, 0, 0, 16'h0000, 4'd0, 0, 4'd0, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
